// File: rtl/ram_arbiter_pkg.sv
// ============================================================================
// ram_arbiter_pkg : shared types and constants for the RAM arbiter slice
// Rev 1.0
// ============================================================================
`default_nettype none

package ram_arbiter_pkg;

  localparam int c_ADDR_W = 6;
  localparam int c_DATA_W = 16;
  localparam int c_DEPTH  = 1 << c_ADDR_W;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2,
    CLEAR  = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/ram_sp_core.sv
// ============================================================================
// ram_sp_core : single-port RAM, synchronous write, registered synchronous read
// Rev 1.0
// ============================================================================
`default_nettype none

module ram_sp_core
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_W = c_ADDR_W,
  parameter int DATA_W = c_DATA_W,
  parameter int DEPTH  = c_DEPTH
) (
  input  logic              clk,
  input  logic              i_en,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) begin
        r_mem[i_addr] <= i_wdata;
      end else begin
        r_rdata <= r_mem[i_addr];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/ram_arbiter.sv
// ============================================================================
// ram_arbiter : round-robin two-requester sequencer for a single-port RAM,
//               with optional sweep-clear engine (RAM_ARBITER_CLEAR_EN)
// Rev 1.0
// ============================================================================
`default_nettype none

module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_W = c_ADDR_W,
  parameter int DATA_W = c_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_rdata,
  input  logic              clear_req,
  output logic              clear_busy
);

  localparam int DEPTH = 1 << ADDR_W;

  state_t            r_state;
  state_t            w_next;
  logic              r_prio;
  logic              r_id;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_a_rdata;
  logic [DATA_W-1:0] r_b_rdata;

  logic              w_grant_b;
  logic              w_start;
  logic              w_resp_rd;
  logic              w_ram_en;
  logic              w_ram_we;
  logic [ADDR_W-1:0] w_ram_addr;
  logic [DATA_W-1:0] w_ram_wdata;
  logic [DATA_W-1:0] w_ram_rdata;

  assign w_grant_b = b_req && (!a_req || (r_prio == REQ_B));

`ifdef RAM_ARBITER_CLEAR_EN
  logic              r_pending;
  logic [ADDR_W-1:0] r_cnt;
  logic              w_clear_go;

  assign w_clear_go = clear_req || r_pending;
  assign clear_busy = (r_state == CLEAR);
`else
  logic w_unused_clear;

  assign w_unused_clear = clear_req;
  assign clear_busy     = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
`ifdef RAM_ARBITER_CLEAR_EN
        if (w_clear_go) w_next = CLEAR;
        else
`endif
        if (a_req || b_req) w_next = ACCESS;
      end
      ACCESS: w_next = RESP;
      RESP:   w_next = IDLE;
`ifdef RAM_ARBITER_CLEAR_EN
      CLEAR:  if (r_cnt == '1) w_next = IDLE;
`endif
      default: w_next = IDLE;
    endcase
  end

  assign w_start = (r_state == IDLE) && (w_next == ACCESS);

  always_comb begin
    w_ram_en    = (r_state == ACCESS);
    w_ram_we    = r_we;
    w_ram_addr  = r_addr;
    w_ram_wdata = r_wdata;
`ifdef RAM_ARBITER_CLEAR_EN
    if (r_state == CLEAR) begin
      w_ram_en    = 1'b1;
      w_ram_we    = 1'b1;
      w_ram_addr  = r_cnt;
      w_ram_wdata = '0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_prio    <= REQ_A;
      r_id      <= REQ_A;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_a_rdata <= '0;
      r_b_rdata <= '0;
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_id    <= w_grant_b ? REQ_B : REQ_A;
        r_we    <= w_grant_b ? b_we : a_we;
        r_addr  <= w_grant_b ? b_addr : a_addr;
        r_wdata <= w_grant_b ? b_wdata : a_wdata;
      end
      if (r_state == RESP) begin
        r_prio <= ~r_id;
      end
      if (w_resp_rd) begin
        if (r_id == REQ_A) r_a_rdata <= w_ram_rdata;
        else               r_b_rdata <= w_ram_rdata;
      end
    end
  end

`ifdef RAM_ARBITER_CLEAR_EN
  // A clear arriving mid-transaction is parked until the next IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pending <= 1'b0;
      r_cnt     <= '0;
    end else begin
      if (r_state == CLEAR) r_cnt <= r_cnt + 1'b1;
      if ((r_state == IDLE) && (w_next == CLEAR)) begin
        r_pending <= 1'b0;
      end else if (clear_req && ((r_state == ACCESS) || (r_state == RESP))) begin
        r_pending <= 1'b1;
      end
    end
  end
`endif

  // Read data goes straight from the RAM register during RESP, then is held.
  assign w_resp_rd = (r_state == RESP) && !r_we;
  assign a_ack     = (r_state == RESP) && (r_id == REQ_A);
  assign b_ack     = (r_state == RESP) && (r_id == REQ_B);
  assign a_rdata   = (w_resp_rd && (r_id == REQ_A)) ? w_ram_rdata : r_a_rdata;
  assign b_rdata   = (w_resp_rd && (r_id == REQ_B)) ? w_ram_rdata : r_b_rdata;

  ram_sp_core #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk     (clk),
    .i_en    (w_ram_en),
    .i_we    (w_ram_we),
    .i_addr  (w_ram_addr),
    .i_wdata (w_ram_wdata),
    .o_rdata (w_ram_rdata)
  );

endmodule

`default_nettype wire

// File: tb/tb_ram_arbiter.sv
// ============================================================================
// tb_ram_arbiter : directed self-checking bench for ram_arbiter
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        a_req = 1'b0, a_we = 1'b0;
  logic [5:0]  a_addr = '0;
  logic [15:0] a_wdata = '0;
  logic        a_ack;
  logic [15:0] a_rdata;
  logic        b_req = 1'b0, b_we = 1'b0;
  logic [5:0]  b_addr = '0;
  logic [15:0] b_wdata = '0;
  logic        b_ack;
  logic [15:0] b_rdata;
  logic        clear_req = 1'b0;
  logic        clear_busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ram_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .a_req      (a_req),
    .a_we       (a_we),
    .a_addr     (a_addr),
    .a_wdata    (a_wdata),
    .a_ack      (a_ack),
    .a_rdata    (a_rdata),
    .b_req      (b_req),
    .b_we       (b_we),
    .b_addr     (b_addr),
    .b_wdata    (b_wdata),
    .b_ack      (b_ack),
    .b_rdata    (b_rdata),
    .clear_req  (clear_req),
    .clear_busy (clear_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transaction from IDLE; lat = cycles from request to ack, -1 on timeout.
  task automatic xact(input bit sel_b, input bit we, input logic [5:0] addr,
                      input logic [15:0] wdata, output logic [15:0] rdata,
                      output int lat);
    if (!sel_b) begin
      a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wdata;
    end else begin
      b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wdata;
    end
    lat = -1;
    rdata = 'x;
    for (int i = 1; i <= 200; i++) begin
      tick();
      if ((sel_b ? b_ack : a_ack) === 1'b1) begin
        lat = i;
        rdata = sel_b ? b_rdata : a_rdata;
        break;
      end
    end
    a_req = 1'b0;
    b_req = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      a_req = 1'($urandom); a_we = 1'($urandom);
      a_addr = 6'($urandom); a_wdata = 16'($urandom);
      b_req = 1'($urandom); b_we = 1'($urandom);
      b_addr = 6'($urandom); b_wdata = 16'($urandom);
      clear_req = 1'($urandom);
      tick();
      checks++;
      if ({a_ack, b_ack, clear_busy, a_rdata, b_rdata} !== 35'd0) begin
        failures++;
        $display("FAIL reset_outputs: got ack=%b/%b busy=%b rdata=%h/%h expected all 0",
                 a_ack, b_ack, clear_busy, a_rdata, b_rdata);
      end
    end
    a_req = 1'b0; b_req = 1'b0; clear_req = 1'b0;
    a_we = 1'b0; b_we = 1'b0;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({a_ack, b_ack, clear_busy} !== 3'b000) begin
        failures++;
        $display("FAIL idle_no_ack: got ack=%b/%b busy=%b expected 0/0/0",
                 a_ack, b_ack, clear_busy);
      end
    end
  endtask

  task automatic test_write_read_a();
    logic [15:0] rd;
    int lat;
    xact(1'b0, 1'b1, 6'h05, 16'hBEEF, rd, lat);
    checks++;
    if (lat !== 2) begin
      failures++;
      $display("FAIL a_write_latency: got %0d expected 2", lat);
    end
    xact(1'b0, 1'b0, 6'h05, 16'h0000, rd, lat);
    checks++;
    if (lat !== 2) begin
      failures++;
      $display("FAIL a_read_latency: got %0d expected 2", lat);
    end
    checks++;
    if (rd !== 16'hBEEF) begin
      failures++;
      $display("FAIL a_read_data: got %h expected beef", rd);
    end
    checks++;
    if (b_rdata !== 16'h0000) begin
      failures++;
      $display("FAIL b_rdata_untouched: got %h expected 0000", b_rdata);
    end
    checks++;
    if (a_rdata !== 16'hBEEF) begin
      failures++;
      $display("FAIL a_rdata_hold: got %h expected beef", a_rdata);
    end
  endtask

  task automatic test_write_read_b();
    logic [15:0] rd;
    int lat;
    xact(1'b1, 1'b1, 6'h3F, 16'hA5A5, rd, lat);
    xact(1'b1, 1'b0, 6'h3F, 16'h0000, rd, lat);
    checks++;
    if (lat !== 2 || rd !== 16'hA5A5) begin
      failures++;
      $display("FAIL b_read: got lat=%0d data=%h expected lat=2 data=a5a5", lat, rd);
    end
    checks++;
    if (a_rdata !== 16'hBEEF) begin
      failures++;
      $display("FAIL a_rdata_hold_on_b: got %h expected beef", a_rdata);
    end
  endtask

  task automatic test_round_robin();
    logic exp_a, exp_b;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    a_req = 1'b1; a_we = 1'b0; a_addr = 6'h05;
    b_req = 1'b1; b_we = 1'b0; b_addr = 6'h3F;
    for (int c = 1; c <= 11; c++) begin
      tick();
      exp_a = (c == 2) || (c == 8);
      exp_b = (c == 5) || (c == 11);
      checks++;
      if ({a_ack, b_ack} !== {exp_a, exp_b}) begin
        failures++;
        $display("FAIL rr_ack_cycle%0d: got a=%b b=%b expected a=%b b=%b",
                 c, a_ack, b_ack, exp_a, exp_b);
      end
      if (c == 2) begin
        checks++;
        if (a_rdata !== 16'hBEEF || b_rdata !== 16'h0000) begin
          failures++;
          $display("FAIL rr_a_data: got a=%h b=%h expected a=beef b=0000", a_rdata, b_rdata);
        end
      end
      if (c == 5) begin
        checks++;
        if (b_rdata !== 16'hA5A5 || a_rdata !== 16'hBEEF) begin
          failures++;
          $display("FAIL rr_b_data: got a=%h b=%h expected a=beef b=a5a5", a_rdata, b_rdata);
        end
      end
    end
    a_req = 1'b0;
    b_req = 1'b0;
    tick();
  endtask

`ifdef RAM_ARBITER_CLEAR_EN
  task automatic test_clear_during_access();
    logic [15:0] rd;
    int lat;
    int busy;
    a_req = 1'b1; a_we = 1'b1; a_addr = 6'h05; a_wdata = 16'h1111;
    tick();
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    checks++;
    if (a_ack !== 1'b1 || clear_busy !== 1'b0) begin
      failures++;
      $display("FAIL clr_write_ack: got ack=%b busy=%b expected ack=1 busy=0", a_ack, clear_busy);
    end
    a_req = 1'b0;
    tick();
    checks++;
    if (clear_busy !== 1'b0 || a_ack !== 1'b0) begin
      failures++;
      $display("FAIL clr_accept_cycle: got busy=%b ack=%b expected 0/0", clear_busy, a_ack);
    end
    tick();
    busy = 0;
    for (int i = 0; i < 200 && clear_busy === 1'b1; i++) begin
      busy++;
      clear_req = (busy == 20);
      tick();
    end
    clear_req = 1'b0;
    checks++;
    if (busy !== 64) begin
      failures++;
      $display("FAIL clr_busy_len: got %0d expected 64", busy);
    end
    tick();
    checks++;
    if (clear_busy !== 1'b0) begin
      failures++;
      $display("FAIL clr_no_restart: got busy=%b expected 0", clear_busy);
    end
    xact(1'b0, 1'b0, 6'h05, 16'h0000, rd, lat);
    checks++;
    if (lat !== 2 || rd !== 16'h0000) begin
      failures++;
      $display("FAIL clr_read_05: got lat=%0d data=%h expected lat=2 data=0000", lat, rd);
    end
    xact(1'b1, 1'b0, 6'h3F, 16'h0000, rd, lat);
    checks++;
    if (lat !== 2 || rd !== 16'h0000) begin
      failures++;
      $display("FAIL clr_read_3f: got lat=%0d data=%h expected lat=2 data=0000", lat, rd);
    end
  endtask

  task automatic test_reset_mid_clear();
    logic [15:0] rd;
    int lat;
    xact(1'b0, 1'b1, 6'h09, 16'h7777, rd, lat);
    xact(1'b0, 1'b1, 6'h20, 16'h1234, rd, lat);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (clear_busy !== 1'b1) begin
      failures++;
      $display("FAIL mid_clear_busy: got %b expected 1", clear_busy);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (clear_busy !== 1'b0) begin
      failures++;
      $display("FAIL mid_clear_abort: got busy=%b expected 0", clear_busy);
    end
    xact(1'b0, 1'b0, 6'h09, 16'h0000, rd, lat);
    checks++;
    if (lat !== 2 || rd !== 16'h0000) begin
      failures++;
      $display("FAIL mid_clear_read_09: got lat=%0d data=%h expected lat=2 data=0000", lat, rd);
    end
    xact(1'b0, 1'b0, 6'h20, 16'h0000, rd, lat);
    checks++;
    if (lat !== 2 || rd !== 16'h1234) begin
      failures++;
      $display("FAIL mid_clear_read_20: got lat=%0d data=%h expected lat=2 data=1234", lat, rd);
    end
  endtask
`else
  task automatic test_clear_disabled();
    logic [15:0] rd;
    int lat;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (clear_busy !== 1'b0) begin
        failures++;
        $display("FAIL nomacro_busy: got %b expected 0", clear_busy);
      end
      tick();
    end
    xact(1'b0, 1'b0, 6'h05, 16'h0000, rd, lat);
    checks++;
    if (lat !== 2 || rd !== 16'hBEEF) begin
      failures++;
      $display("FAIL nomacro_read_05: got lat=%0d data=%h expected lat=2 data=beef", lat, rd);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_write_read_a();
    test_write_read_b();
    test_round_robin();
`ifdef RAM_ARBITER_CLEAR_EN
    test_clear_during_access();
    test_reset_mid_clear();
`else
    test_clear_disabled();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ram_arbiter.md
# ram_arbiter

Two-requester arbiter and sequencer for a 64 x 16 single-port synchronous RAM. Requesters A and B share the one RAM port under round-robin priority. A sweep-clear engine zeroes the whole array over 64 cycles, which replaces a single-cycle all-words clear. The block sits between the two datapath clients and the RAM core, and it is the only agent that drives the RAM port.

## Interface
Parameters:
- ADDR_W, 6, address width
- DATA_W, 16, word width
- DEPTH, 1 << ADDR_W, number of words (derived; not overridden)

Ports:
- clk  in  1  single clock; all logic on posedge clk
- reset  in  1  synchronous, active-high reset
- a_req  in  1  requester A transaction request; held until a_ack
- a_we  in  1  A: 1 = write, 0 = read; stable while a_req is high
- a_addr  in  ADDR_W  A address
- a_wdata  in  DATA_W  A write data
- a_ack  out  1  one-cycle completion pulse for A
- a_rdata  out  DATA_W  A read data, registered, valid with a_ack
- b_req, b_we, b_addr, b_wdata, b_ack, b_rdata  same as A, for requester B
- clear_req  in  1  one-cycle pulse requesting an array clear
- clear_busy  out  1  high while the clear sweep runs

## Operation
- FSM states: IDLE, ACCESS, RESP, CLEAR.
- IDLE behaviour:
  - A pending clear (clear_req, or a latched pending clear) goes to CLEAR. Clear has priority over both requesters.
  - Otherwise, if one req is high, that requester wins.
  - If both are high, the requester named by the prio bit wins.
  - The winner's id, we, addr and wdata are registered, and the FSM goes to ACCESS.
- ACCESS: drive the RAM port with the registered op, either a write or a synchronous read. Go to RESP.
- RESP:
  - Pulse the winner's ack.
  - For a read, load the winner's rdata from the RAM output. The other requester's rdata holds its value.
  - Set prio to the non-winner. Go to IDLE.
- CLEAR:
  - A 6-bit counter writes 0 to addresses 0..63, one word per cycle.
  - After address 63 is written, go to IDLE. The pending flag clears on entry to CLEAR.
- A clear_req that arrives in ACCESS or RESP sets the pending flag. The flag is serviced at the next IDLE.
- A clear_req that arrives during CLEAR is ignored. It does not restart the sweep.
- A requester may keep req high after ack to issue back-to-back transactions. With contention, service alternates A, B, A, B.
- A read of address X issued after a write to X has completed returns the new data.

## Timing
- Reset values:
  - State IDLE, prio = A.
  - a_ack = b_ack = 0; a_rdata = b_rdata = 0.
  - clear_busy = 0; pending flag = 0; counter = 0.
  - RAM contents are not reset.
- Latency: req is sampled in IDLE at cycle N; ack and rdata appear at cycle N+2.
- Throughput: one transaction per 3 cycles.
- clear_busy rises in the cycle after the clear is accepted. It stays high for exactly 64 cycles (covering addresses 0..63) and falls the cycle after address 63 is written.
- A request arriving during CLEAR waits. It is accepted in the first IDLE cycle after the sweep.
- Reset mid-transaction: the transaction is dropped and no ack is issued.
- Reset mid-clear: the sweep aborts and clear_busy is 0 in the next cycle. Addresses not yet swept keep their old data.
- Deasserting req before ack is illegal and the behaviour is undefined.

## Configuration
- RAM_ARBITER_CLEAR_EN defined: the CLEAR state, counter, pending flag and clear_busy logic are compiled in.
- RAM_ARBITER_CLEAR_EN undefined:
  - clear_req is ignored and clear_busy is tied to 0.
  - The FSM has only IDLE, ACCESS and RESP.
  - Port list is unchanged.

## Structure
- Package ram_arbiter_pkg holds:
  - the state enum (IDLE, ACCESS, RESP, CLEAR)
  - default ADDR_W, DATA_W and DEPTH constants
  - the requester-id encoding: REQ_A = 0, REQ_B = 1
- Sub-module ram_sp_core: a 64 x 16 single-port RAM with write enable, synchronous write and registered synchronous read. It is instantiated once and driven only by the arbiter.

## Test plan
- Reset check: hold reset 2 cycles with random inputs -> all outputs 0 and no ack. Release -> idle with no ack while req is low.
- A write then read: write 0xBEEF to 0x05, then read 0x05 -> a_ack at sample+2, a_rdata = 0xBEEF, b_rdata stays 0.
- Round-robin: after reset, a_req and b_req both high (reads) -> a_ack at cycle 2, b_ack at cycle 5. Both held again -> the next grant order is A, then B.
- Clear during access: clear_req one cycle after an A write is accepted -> the A write acks, then clear_busy is high 64 cycles, then reads of 0x05 and 0x3F return 0x0000.
- Reset mid-clear: reset at sweep cycle 10 -> clear_busy is 0 the next cycle. Address 0x09 reads 0x0000; address 0x20 reads its pre-clear value 0x1234.
- Macro undefined: clear_req pulse -> clear_busy stays 0 and a read of 0x05 still returns 0xBEEF.
